pixel_stream_gen: RTL and testbench

PIXEL_STREAM_GEN -- requirements
Module: pixel_stream_gen

---
 rtl/pixel_stream_if.sv | 16 +
 rtl/pixel_stream_gen.sv | 84 ++++++++
 tb/tb_pixel_stream_gen.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_if.sv
// pixel_stream_if: AXI-Stream style pixel bus between the generator and its sink.
//   tdata  : 32-bit pixel word {8'h00, r, g, b}
//   tvalid : beat valid (master -> slave)
//   tready : sink ready (slave -> master)
//   tuser  : start of frame, set on pixel (0,0) only
//   tlast  : end of line, set on the last pixel of each line
interface pixel_stream_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: raster scan generator that walks x,y over an H_RES x V_RES frame,
// samples the combinational colour stage for the current x,y and streams the pixels
// out with AXI-Stream handshaking, one pixel per clock when the sink is ready.
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : frame enable, only looked at when no frame is in progress
//   x, y       : current pixel column / row presented to the colour stage
//   r, g, b    : colour for the current x,y (combinational from the colour stage)
//   m          : pixel stream master (tdata, tvalid, tready, tuser, tlast)
//   frame_done : one-cycle pulse after the last pixel of a frame is loaded
//   frame_cnt  : completed-frame counter, present only with FRAME_COUNTER_EN defined
module pixel_stream_gen #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [9:0]  x,
    output logic [9:0]  y,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    pixel_stream_if.master m,
`ifdef FRAME_COUNTER_EN
    output logic [15:0] frame_cnt,
`endif
    output logic        frame_done
);
    logic frame_active;
    logic load;
    logic x_end;
    logic y_end;
    logic origin;

    assign x_end  = x == 10'(H_RES - 1);
    assign y_end  = y == 10'(V_RES - 1);
    assign origin = x == 10'd0 && y == 10'd0;
    // The output register can take a new pixel when it is empty or being drained;
    // en only matters between frames since frame_active keeps a started frame going.
    assign load   = (!m.tvalid || m.tready) && (frame_active || en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x            <= '0;
            y            <= '0;
            m.tdata      <= '0;
            m.tvalid     <= 1'b0;
            m.tuser      <= 1'b0;
            m.tlast      <= 1'b0;
            frame_done   <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            frame_done <= load && x_end && y_end;
            if (load) begin
                m.tdata  <= {8'h00, r, g, b};
                m.tvalid <= 1'b1;
                m.tuser  <= origin;
                m.tlast  <= x_end;
                x        <= x_end ? 10'd0 : x + 10'd1;
                if (x_end)
                    y <= y_end ? 10'd0 : y + 10'd1;
                // The last pixel clears the frame so the next (0,0) load re-samples en,
                // which still lets a held-high en start the next frame back to back.
                if (x_end && y_end)
                    frame_active <= 1'b0;
                else if (origin)
                    frame_active <= 1'b1;
            end else if (m.tready) begin
                m.tvalid <= 1'b0;
            end
        end
    end

`ifdef FRAME_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pixel_stream_gen.sv
// tb_pixel_stream_gen: scoreboard bench for pixel_stream_gen on a 4x2 frame plus a
// 640x3 instance for line-length boundaries.
module tb_pixel_stream_gen;
    localparam int H = 4;
    localparam int V = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic       frame_done;
    logic       en2 = 1'b0;
    logic [9:0] x2, y2;
    logic       done2;
`ifdef FRAME_COUNTER_EN
    logic [15:0] frame_cnt, frame_cnt2;
`endif

    pixel_stream_if bus();
    pixel_stream_if bus2();

    always #5 clk = ~clk;

    assign r = x[7:0];
    assign g = y[7:0];
    assign b = 8'hAA;

    pixel_stream_gen #(.H_RES(H), .V_RES(V)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .x(x), .y(y),
        .r(r), .g(g), .b(b), .m(bus),
`ifdef FRAME_COUNTER_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_done(frame_done)
    );

    pixel_stream_gen #(.V_RES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .x(x2), .y(y2),
        .r(x2[7:0]), .g(y2[7:0]), .b(8'h55), .m(bus2),
`ifdef FRAME_COUNTER_EN
        .frame_cnt(frame_cnt2),
`endif
        .frame_done(done2)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int beats = 0;
    int dones = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int beats2 = 0;
    int tlast2 = 0;
    int dones2 = 0;
    int xmax2 = 0;
    int ymax2 = 0;
    logic [33:0] q[$];
    logic [33:0] e_mon;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] beat(int px, int py);
        return {1'(px == 0 && py == 0), 1'(px == H - 1), 8'h00, 8'(px), 8'(py), 8'hAA};
    endfunction

    task automatic push_frame();
        for (int py = 0; py < V; py++)
            for (int px = 0; px < H; px++)
                q.push_back(beat(px, py));
    endtask

    task automatic pulse_en();
        @(posedge clk); #1;
        push_frame();
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, q.size(), 0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.tvalid && bus.tready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", q.size(), 1);
            end else begin
                e_mon = q.pop_front();
                check("tdata", bus.tdata, e_mon[31:0]);
                check("tuser", bus.tuser, e_mon[33]);
                check("tlast", bus.tlast, e_mon[32]);
                beats++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        if (frame_done) begin
            dones++;
            check("done_with_beat7", {bus.tvalid, bus.tlast, bus.tdata}, {2'b11, 32'h0003_01AA});
        end
        if (bus2.tvalid && bus2.tready) begin
            beats2++;
            if (bus2.tlast) begin
                tlast2++;
                check("tlast_position_640", beats2 % 640, 0);
            end
        end
        if (int'(x2) > xmax2) xmax2 = int'(x2);
        if (int'(y2) > ymax2) ymax2 = int'(y2);
        if (done2) dones2++;
    end

    initial begin
        int n;
        int dones0;
        bus.tready  = 1'b1;
        bus2.tready = 1'b1;
        #12;
        check("rst_tvalid", bus.tvalid, 0);
        check("rst_tdata", bus.tdata, 0);
        check("rst_xy", {x, y}, 0);
        check("rst_user_last_done", {bus.tuser, bus.tlast, frame_done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", bus.tvalid, 0);

        // single-cycle en pulse: exactly one full frame, then idle
        pulse_en();
        wait_drain("drain_frame1");
        repeat (3) @(negedge clk);
        check("idle_tvalid", bus.tvalid, 0);
        check("idle_xy", {x, y}, 0);
        check("frame1_beats", beats, 8);
        check("frame1_dones", dones, 1);

        // back-pressure while x=2,y=0 is presented to the colour stage
        pulse_en();
        n = 0;
        while (x != 10'd2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_x2", x, 2);
        bus.tready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_tdata", bus.tdata, 32'h0001_00AA);
            check("stall_xy", {x, y}, {10'd2, 10'd0});
            check("stall_valid_last", {bus.tvalid, bus.tlast}, 2'b10);
        end
        @(posedge clk); #1;
        bus.tready = 1'b1;
        wait_drain("drain_stall");
        check("stall_beats", beats, 16);
        check("stall_dones", dones, 2);

        // asynchronous reset in the middle of a frame
        pulse_en();
        n = 0;
        while (beats < 21 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_tvalid_user_last", {bus.tvalid, bus.tuser, bus.tlast}, 0);
        check("arst_tdata", bus.tdata, 0);
        check("arst_xy_done", {x, y, frame_done}, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post_rst_xy", {x, y}, 0);
        pulse_en();
        wait_drain("drain_after_rst");
        check("after_rst_dones", dones, 3);

        // three back-to-back frames from a clean reset
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones0 = dones;
        first_cyc = -1;
        push_frame();
        push_frame();
        push_frame();
        en = 1'b1;
        n = 0;
        while (dones < dones0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        en = 1'b0;
        wait_drain("drain_3frames");
        repeat (3) @(negedge clk);
        check("3frames_span", last_cyc - first_cyc, 23);
        check("3frames_dones", dones - dones0, 3);
`ifdef FRAME_COUNTER_EN
        check("frame_cnt", frame_cnt, 3);
`endif

        // default line length on a short 640x3 frame
        @(posedge clk); #1;
        en2 = 1'b1;
        @(posedge clk); #1;
        en2 = 1'b0;
        n = 0;
        while (dones2 < 1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("big_beats", beats2, 1920);
        check("big_tlasts", tlast2, 3);
        check("big_xmax", xmax2, 639);
        check("big_ymax", ymax2, 2);
        check("big_dones", dones2, 1);
        check("big_idle", bus2.tvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
